sda_kernel_ctrl: RTL

Host-facing control block for one kernel action. Exposes a 32-bit AXI4-Lite register slave to the host shell, sequences the action's go/done handshakes from a host start command, reports done/idle status, raises a maskable interrupt and measures run time in clock cycles. It sits between the shell's control AXI-Lite port and the `go_0*`/`done_0*` ports of `teak_action_top`.

---
 rtl/sda_ctrl_pkg.sv | 34 +++
 rtl/sda_ctrl_axil_regs.sv | 127 ++++++++++++
 rtl/sda_kernel_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/sda_ctrl_pkg.sv
// rtl/sda_ctrl_pkg.sv - shared constants for the kernel action control block
package sda_ctrl_pkg;

    localparam int unsigned REG_CTRL   = 32'h00;
    localparam int unsigned REG_GIE    = 32'h04;
    localparam int unsigned REG_IER    = 32'h08;
    localparam int unsigned REG_ISR    = 32'h0C;
    localparam int unsigned REG_CYCLES = 32'h10;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_DONE_BIT  = 1;
    localparam int CTRL_IDLE_BIT  = 2;
    localparam int CTRL_RUN_BIT   = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GO    = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    function automatic logic [31:0] ctrl_word(input logic start, input logic done,
                                              input logic idle, input logic run);
        logic [31:0] w;
        w = '0;
        w[CTRL_START_BIT] = start;
        w[CTRL_DONE_BIT]  = done;
        w[CTRL_IDLE_BIT]  = idle;
        w[CTRL_RUN_BIT]   = run;
        return w;
    endfunction

endpackage

// File: rtl/sda_ctrl_axil_regs.sv
// rtl/sda_ctrl_axil_regs.sv - AXI-Lite channel handshakes and control register file
module sda_ctrl_axil_regs
    import sda_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic              go_accept,
    input  logic              done_event,
    input  logic              fsm_idle,
    input  logic              fsm_run,
    input  logic [31:0]       cycles,
    output logic              start_req,
    output logic              gie,
    output logic              ier,
    output logic              isr
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(REG_CTRL >> 2);
    localparam logic [IDX_W-1:0] IDX_GIE    = IDX_W'(REG_GIE >> 2);
    localparam logic [IDX_W-1:0] IDX_IER    = IDX_W'(REG_IER >> 2);
    localparam logic [IDX_W-1:0] IDX_ISR    = IDX_W'(REG_ISR >> 2);
    localparam logic [IDX_W-1:0] IDX_CYCLES = IDX_W'(REG_CYCLES >> 2);

    logic             wr_fire, rd_fire, lane0_bit0;
    logic             start_bit, done_bit, start_wr, isr_toggle;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [31:0]      rd_word;
    logic             unused_bits;

    assign wr_fire       = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
    assign rd_fire       = s_axi_arvalid & ~s_axi_rvalid;
    assign s_axi_awready = wr_fire;
    assign s_axi_wready  = wr_fire;
    assign s_axi_arready = rd_fire;
    assign s_axi_bresp   = AXI_RESP_OKAY;
    assign s_axi_rresp   = AXI_RESP_OKAY;

    assign wr_idx     = s_axi_awaddr[ADDR_W-1:2];
    assign rd_idx     = s_axi_araddr[ADDR_W-1:2];
    assign lane0_bit0 = s_axi_wstrb[0] & s_axi_wdata[0];
    assign start_wr   = wr_fire && (wr_idx == IDX_CTRL) && lane0_bit0;
    assign isr_toggle = wr_fire && (wr_idx == IDX_ISR) && lane0_bit0;

    // A fresh START write launches from IDLE on its own edge, so go_0r follows one cycle later.
    assign start_req = start_bit | start_wr;

    assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata[31:1], s_axi_wstrb[3:1]};

    always_comb begin
        rd_word = '0;
        case (rd_idx)
            IDX_CTRL:   rd_word = ctrl_word(start_bit, done_bit, fsm_idle, fsm_run);
            IDX_GIE:    rd_word = {31'b0, gie};
            IDX_IER:    rd_word = {31'b0, ier};
            IDX_ISR:    rd_word = {31'b0, isr};
            IDX_CYCLES: rd_word = cycles;
            default:    rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_bit    <= 1'b0;
            done_bit     <= 1'b0;
            gie          <= 1'b0;
            ier          <= 1'b0;
            isr          <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
        end else begin
            if (go_accept)
                start_bit <= 1'b0;
            if (start_wr)
                start_bit <= 1'b1;

            // Set beats clear-on-read: ordering below lets a coincident done event win.
            if (rd_fire && rd_idx == IDX_CTRL)
                done_bit <= 1'b0;
            if (done_event)
                done_bit <= 1'b1;

            if (isr_toggle)
                isr <= ~isr;
            if (done_event)
                isr <= 1'b1;

            if (wr_fire && wr_idx == IDX_GIE && s_axi_wstrb[0])
                gie <= s_axi_wdata[0];
            if (wr_fire && wr_idx == IDX_IER && s_axi_wstrb[0])
                ier <= s_axi_wdata[0];

            if (wr_fire)
                s_axi_bvalid <= 1'b1;
            else if (s_axi_bready)
                s_axi_bvalid <= 1'b0;

            if (rd_fire) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_word;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sda_kernel_ctrl.sv
// rtl/sda_kernel_ctrl.sv - host control block sequencing one kernel action's go/done handshakes
module sda_kernel_ctrl
    import sda_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              go_0r,
    input  logic              go_0a,
    input  logic              done_0r,
    output logic              done_0a,
    output logic              interrupt
);

    logic [2:0]  state, state_nxt;
    logic [31:0] cycles;
    logic        start_req, gie, ier, isr;
    logic        go_accept, done_event;

    assign go_0r      = (state == ST_GO);
    assign done_0a    = (state == ST_ACK);
    assign go_accept  = go_0r & go_0a;
    assign done_event = (state == ST_RUN) & done_0r;
    assign interrupt  = gie & ier & isr;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_req) state_nxt = ST_GO;
            ST_GO:    if (go_0a)     state_nxt = ST_RUN;
            ST_RUN:   if (done_0r)   state_nxt = ST_ACK;
            ST_ACK:                  state_nxt = ST_DRAIN;
            ST_DRAIN: if (!done_0r)  state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cycles <= '0;
        end else begin
            state <= state_nxt;
            // Run time covers GO and RUN only; the value is held for the host after completion.
            if (state == ST_IDLE && start_req)
                cycles <= '0;
            else if ((state == ST_GO || state == ST_RUN) && cycles != 32'hFFFF_FFFF)
                cycles <= cycles + 32'd1;
        end
    end

    sda_ctrl_axil_regs #(
        .ADDR_W(ADDR_W)
    ) u_regs (
        .clk           (clk),
        .reset         (reset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .go_accept     (go_accept),
        .done_event    (done_event),
        .fsm_idle      (state == ST_IDLE),
        .fsm_run       (state == ST_RUN),
        .cycles        (cycles),
        .start_req     (start_req),
        .gie           (gie),
        .ier           (ier),
        .isr           (isr)
    );

endmodule
